arp_reply_gen: RTL and testbench
================================

# arp_reply_gen

Consumes parsed ARP frames from the ARP receive stage and checks each one. For an IPv4-over-Ethernet request that targets the local IP, it builds the ARP reply fields in parallel for the ARP transmit stage. It also learns sender IP/MAC bindings into a small cache that the IP transmit path can query. It sits between the ARP frame receiver and the ARP frame transmitter.

## Interface
- CACHE_ENTRIES, 4: number of cache entries; must be a power of two, 2..16.
- CACHE_PTR_WIDTH, $clog2(CACHE_ENTRIES): replacement pointer width; derived, not overridden.

- clk  in  1  single clock for all logic
- rst_n  in  1  reset; asynchronous, active-low
- s_frame_valid / s_frame_ready  in / out  1 / 1  input ARP frame handshake
- s_eth_dest_mac, s_eth_src_mac  in  48  received Ethernet addresses
- s_eth_type  in  16  received ethertype
- s_arp_htype, s_arp_ptype, s_arp_oper  in  16  ARP header fields
- s_arp_hlen, s_arp_plen  in  8  ARP length fields
- s_arp_sha, s_arp_tha  in  48  sender / target hardware address
- s_arp_spa, s_arp_tpa  in  32  sender / target protocol address
- local_mac  in  48  this node's MAC; quasi-static
- local_ip  in  32  this node's IP; quasi-static
- m_frame_valid / m_frame_ready  out / in  1 / 1  reply frame handshake
- m_eth_dest_mac, m_eth_src_mac  out  48  reply Ethernet addresses
- m_eth_type, m_arp_htype, m_arp_ptype, m_arp_oper  out  16  reply fields
- m_arp_hlen, m_arp_plen  out  8  reply length fields
- m_arp_sha, m_arp_tha  out  48  reply hardware addresses
- m_arp_spa, m_arp_tpa  out  32  reply protocol addresses
- lookup_req_valid / lookup_req_ready  in / out  1 / 1  cache query handshake
- lookup_req_ip  in  32  IP to resolve
- lookup_resp_valid  out  1  one-cycle response pulse
- lookup_resp_hit  out  1  query matched an entry
- lookup_resp_mac  out  48  matched MAC; 0 on miss
- stat_reply_sent  out  1  pulse on each reply handshake
- stat_frame_drop  out  1  pulse on each frame discarded without reply

## Operation
- States: IDLE, CHECK, REPLY.
- IDLE
  - s_frame_ready=1.
  - On s_frame_valid: register all s_* fields and go to CHECK.
- CHECK (one cycle)
  - valid = htype==1 && ptype==16'h0800 && hlen==6 && plen==4.
  - reply = valid && oper==1 && tpa==local_ip && local_ip!=0.
  - reply: load the m_* registers and go to REPLY.
  - Otherwise: pulse stat_frame_drop and go to IDLE.
  - Learn: if valid && (oper==1 || oper==2) && spa!=0, write the cache.
- REPLY
  - m_frame_valid=1, outputs held stable.
  - On m_frame_ready: pulse stat_reply_sent and go to IDLE.
- Reply fields:
  - eth_dest_mac = request sha; eth_src_mac = local_mac; eth_type = 16'h0806.
  - htype 1; ptype 16'h0800; hlen 6; plen 4; oper 2.
  - sha = local_mac; spa = local_ip; tha = request sha; tpa = request spa.
- Cache write:
  - If an entry's IP equals spa, overwrite that entry's MAC.
  - Otherwise write into the entry at the round-robin pointer, set it valid, and increment the pointer (wraps at CACHE_ENTRIES-1 → 0).
- Cache lookup:
  - Accepted when lookup_req_valid && lookup_req_ready.
  - lookup_req_ready=0 only in a cycle where a cache write occurs; writes have priority.

## Timing
- Reset values:
  - All outputs are 0, including s_frame_ready and lookup_req_ready; cache valid bits cleared; pointer 0.
  - s_frame_ready and lookup_req_ready rise in the first cycle after rst_n deasserts.
- Frame latency:
  - Frame accepted at cycle N → CHECK at N+1 → m_frame_valid at N+2.
  - After the reply handshake at cycle M, s_frame_ready=1 at M+1.
  - Dropped frame: s_frame_ready returns 1 at N+2.
- Lookup latency: request accepted at N → lookup_resp_* valid at N+1 only.
  - Lookup of an IP written in the same cycle returns the pre-write contents.
- Back-to-back lookups are accepted every cycle; no backpressure on responses.
- Reset asserted mid-REPLY drops the pending reply; no stat pulse.
- local_mac and local_ip are sampled in CHECK; later changes do not alter a held reply.

## Configuration
- ARP_CACHE_EN defined: cache, learning and lookup operate as above.
- ARP_CACHE_EN undefined:
  - No cache storage.
  - lookup_req_ready=1 after reset; each query gets lookup_resp_valid at N+1 with hit=0 and mac=0.
  - Reply generation is unchanged.

## Structure
- Shared package arp_pkg holds:
  - ARP_HTYPE_ETH=1, ARP_PTYPE_IPV4=16'h0800, ETHERTYPE_ARP=16'h0806.
  - ARP_OPER_REQUEST=1, ARP_OPER_REPLY=2.
  - State encodings.
- Sub-module arp_cache contains the entry array, the match/replace logic and the lookup port. It is instantiated only under ARP_CACHE_EN.

## Test plan
- local_ip=10.0.0.1: request with tpa=10.0.0.1, sha=02:00:00:00:00:AA, spa=10.0.0.2 → m_frame_valid at N+2; oper=2, tha=02:..:AA, tpa=10.0.0.2, eth_dest_mac=02:..:AA; stat_reply_sent=1 on handshake.
- Request with tpa=10.0.0.9 → no m_frame_valid, stat_frame_drop pulse. A following lookup of 10.0.0.2 returns hit=1, mac=sha.
- hlen=5 request for the local IP → dropped, no reply, no cache write.
- m_frame_ready held 0 for 10 cycles → m_* stable and s_frame_ready=0 throughout; a single handshake completes the reply.
- Five distinct senders with CACHE_ENTRIES=4 → lookup of the first sender misses, the fifth hits. Re-learning sender 2 with a new MAC updates it in place.
- Reset asserted while in REPLY → all outputs 0; after release, a fresh request is answered normally.

Source files
------------

// File: rtl/arp_pkg.sv
// arp_pkg: shared ARP constants, FSM state encodings and the header check helper
// used by arp_reply_gen and arp_cache.
package arp_pkg;

   localparam logic [15:0] ARP_HTYPE_ETH    = 16'd1;
   localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
   localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
   localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
   localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;
   localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
   localparam logic [7:0]  ARP_PLEN_IPV4    = 8'd4;

   // Frame handler FSM encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_REPLY = 2'd2;

   // True for an IPv4-over-Ethernet ARP header
   function automatic logic arp_hdr_ok(input logic [15:0] htype,
                                       input logic [15:0] ptype,
                                       input logic [7:0]  hlen,
                                       input logic [7:0]  plen);
      return (htype == ARP_HTYPE_ETH) && (ptype == ARP_PTYPE_IPV4) &&
             (hlen == ARP_HLEN_ETH) && (plen == ARP_PLEN_IPV4);
   endfunction

endpackage

// File: rtl/arp_cache.sv
// arp_cache: small fully-associative IP->MAC binding table.
//   wr_en_i/wr_ip_i/wr_mac_i : learn port; an existing IP is updated in place,
//                              otherwise the round-robin slot is replaced
//   lk_en_i/lk_ip_i          : accepted lookup request
//   lk_valid_o/lk_hit_o/lk_mac_o : registered response, one cycle after request
// Lookups see the table contents before any write in the same cycle.
module arp_cache #(
   parameter int unsigned CACHE_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en_i,
   input  logic [31:0] wr_ip_i,
   input  logic [47:0] wr_mac_i,
   input  logic        lk_en_i,
   input  logic [31:0] lk_ip_i,
   output logic        lk_valid_o,
   output logic        lk_hit_o,
   output logic [47:0] lk_mac_o
);
   import arp_pkg::*;

   localparam int unsigned CACHE_PTR_WIDTH = $clog2(CACHE_ENTRIES);

   logic [31:0]                ip_q  [CACHE_ENTRIES];
   logic [47:0]                mac_q [CACHE_ENTRIES];
   logic [CACHE_ENTRIES-1:0]   vld_q;
   logic [CACHE_PTR_WIDTH-1:0] ptr_q;

   logic                       wr_match;
   logic [CACHE_PTR_WIDTH-1:0] wr_idx;
   logic                       lk_hit_d;
   logic [47:0]                lk_mac_d;
   logic                       resp_valid_q, resp_hit_q;
   logic [47:0]                resp_mac_q;

   always_comb begin
      wr_match = 1'b0;
      wr_idx   = ptr_q;
      for (int unsigned i = 0; i < CACHE_ENTRIES; i++) begin
         if (vld_q[i] && (ip_q[i] == wr_ip_i)) begin
            wr_match = 1'b1;
            wr_idx   = CACHE_PTR_WIDTH'(i);
         end
      end
   end

   always_comb begin
      lk_hit_d = 1'b0;
      lk_mac_d = '0;
      for (int unsigned i = 0; i < CACHE_ENTRIES; i++) begin
         if (vld_q[i] && (ip_q[i] == lk_ip_i)) begin
            lk_hit_d = 1'b1;
            lk_mac_d = mac_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         ptr_q <= '0;
         for (int unsigned i = 0; i < CACHE_ENTRIES; i++) begin
            ip_q[i]  <= '0;
            mac_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         ip_q[wr_idx]  <= wr_ip_i;
         mac_q[wr_idx] <= wr_mac_i;
         vld_q[wr_idx] <= 1'b1;
         // Pointer only advances on a fresh allocation; power-of-two size wraps naturally
         if (!wr_match) ptr_q <= ptr_q + CACHE_PTR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_mac_q   <= '0;
      end else begin
         resp_valid_q <= lk_en_i;
         resp_hit_q   <= lk_en_i && lk_hit_d;
         resp_mac_q   <= lk_en_i ? lk_mac_d : '0;
      end
   end

   assign lk_valid_o = resp_valid_q;
   assign lk_hit_o   = resp_hit_q;
   assign lk_mac_o   = resp_mac_q;

endmodule

// File: rtl/arp_reply_gen.sv
// arp_reply_gen: checks parsed ARP frames, builds replies to requests for the
// local IP and (optionally) learns sender bindings into a lookup cache.
//   s_frame_* / s_eth_* / s_arp_* : parsed frame from the ARP receiver
//   local_mac / local_ip          : this node's addresses (sampled in CHECK)
//   m_frame_* / m_eth_* / m_arp_* : reply frame to the ARP transmitter
//   lookup_req_* / lookup_resp_*  : IP->MAC query port for the IP tx path
//   stat_reply_sent / stat_frame_drop : single-cycle event pulses
// Optional feature: define ARP_CACHE_EN to build the cache; otherwise lookups
// always answer with a miss.
module arp_reply_gen #(
   parameter int unsigned CACHE_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_frame_valid,
   output logic        s_frame_ready,
   input  logic [47:0] s_eth_dest_mac,
   input  logic [47:0] s_eth_src_mac,
   input  logic [15:0] s_eth_type,
   input  logic [15:0] s_arp_htype,
   input  logic [15:0] s_arp_ptype,
   input  logic [15:0] s_arp_oper,
   input  logic [7:0]  s_arp_hlen,
   input  logic [7:0]  s_arp_plen,
   input  logic [47:0] s_arp_sha,
   input  logic [47:0] s_arp_tha,
   input  logic [31:0] s_arp_spa,
   input  logic [31:0] s_arp_tpa,
   input  logic [47:0] local_mac,
   input  logic [31:0] local_ip,
   output logic        m_frame_valid,
   input  logic        m_frame_ready,
   output logic [47:0] m_eth_dest_mac,
   output logic [47:0] m_eth_src_mac,
   output logic [15:0] m_eth_type,
   output logic [15:0] m_arp_htype,
   output logic [15:0] m_arp_ptype,
   output logic [15:0] m_arp_oper,
   output logic [7:0]  m_arp_hlen,
   output logic [7:0]  m_arp_plen,
   output logic [47:0] m_arp_sha,
   output logic [47:0] m_arp_tha,
   output logic [31:0] m_arp_spa,
   output logic [31:0] m_arp_tpa,
   input  logic        lookup_req_valid,
   output logic        lookup_req_ready,
   input  logic [31:0] lookup_req_ip,
   output logic        lookup_resp_valid,
   output logic        lookup_resp_hit,
   output logic [47:0] lookup_resp_mac,
   output logic        stat_reply_sent,
   output logic        stat_frame_drop
);
   import arp_pkg::*;

   localparam int unsigned CACHE_PTR_WIDTH = $clog2(CACHE_ENTRIES);

   if ((CACHE_ENTRIES < 2) || (CACHE_ENTRIES > 16) ||
       ((32'd1 << CACHE_PTR_WIDTH) != CACHE_ENTRIES)) begin : g_bad_cfg
      $error("arp_reply_gen: CACHE_ENTRIES must be a power of two in 2..16");
   end

   logic [1:0]  state_q, state_d;
   logic        s_ready_q, lk_en_q;
   logic [15:0] req_htype_q, req_ptype_q, req_oper_q;
   logic [7:0]  req_hlen_q, req_plen_q;
   logic [47:0] req_sha_q;
   logic [31:0] req_spa_q, req_tpa_q;
   logic        accept, in_check, frame_ok, do_reply;

   // Ethernet header and target MAC of the request are not needed for the reply
   logic unused_rx;
   assign unused_rx = ^{s_eth_dest_mac, s_eth_src_mac, s_eth_type, s_arp_tha};

   assign accept   = s_ready_q && s_frame_valid;
   assign in_check = (state_q == ST_CHECK);
   assign frame_ok = arp_hdr_ok(req_htype_q, req_ptype_q, req_hlen_q, req_plen_q);
   assign do_reply = frame_ok && (req_oper_q == ARP_OPER_REQUEST) &&
                     (req_tpa_q == local_ip) && (local_ip != '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_CHECK;
         ST_CHECK: state_d = do_reply ? ST_REPLY : ST_IDLE;
         ST_REPLY: if (m_frame_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Ready is registered so it stays low throughout reset and rises one clock later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         s_ready_q <= 1'b0;
         lk_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d == ST_IDLE);
         lk_en_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_htype_q <= '0;
         req_ptype_q <= '0;
         req_oper_q  <= '0;
         req_hlen_q  <= '0;
         req_plen_q  <= '0;
         req_sha_q   <= '0;
         req_spa_q   <= '0;
         req_tpa_q   <= '0;
      end else if (accept) begin
         req_htype_q <= s_arp_htype;
         req_ptype_q <= s_arp_ptype;
         req_oper_q  <= s_arp_oper;
         req_hlen_q  <= s_arp_hlen;
         req_plen_q  <= s_arp_plen;
         req_sha_q   <= s_arp_sha;
         req_spa_q   <= s_arp_spa;
         req_tpa_q   <= s_arp_tpa;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_eth_dest_mac <= '0;
         m_eth_src_mac  <= '0;
         m_eth_type     <= '0;
         m_arp_htype    <= '0;
         m_arp_ptype    <= '0;
         m_arp_oper     <= '0;
         m_arp_hlen     <= '0;
         m_arp_plen     <= '0;
         m_arp_sha      <= '0;
         m_arp_tha      <= '0;
         m_arp_spa      <= '0;
         m_arp_tpa      <= '0;
      end else if (in_check && do_reply) begin
         m_eth_dest_mac <= req_sha_q;
         m_eth_src_mac  <= local_mac;
         m_eth_type     <= ETHERTYPE_ARP;
         m_arp_htype    <= ARP_HTYPE_ETH;
         m_arp_ptype    <= ARP_PTYPE_IPV4;
         m_arp_oper     <= ARP_OPER_REPLY;
         m_arp_hlen     <= ARP_HLEN_ETH;
         m_arp_plen     <= ARP_PLEN_IPV4;
         m_arp_sha      <= local_mac;
         m_arp_tha      <= req_sha_q;
         m_arp_spa      <= local_ip;
         m_arp_tpa      <= req_spa_q;
      end
   end

   assign s_frame_ready   = s_ready_q;
   assign m_frame_valid   = (state_q == ST_REPLY);
   assign stat_reply_sent = m_frame_valid && m_frame_ready;
   assign stat_frame_drop = in_check && !do_reply;

`ifdef ARP_CACHE_EN
   logic learn;
   assign learn = in_check && frame_ok && (req_spa_q != '0) &&
                  ((req_oper_q == ARP_OPER_REQUEST) || (req_oper_q == ARP_OPER_REPLY));
   // Learning owns the table in its write cycle, so queries are held off then
   assign lookup_req_ready = lk_en_q && !learn;

   arp_cache #(
      .CACHE_ENTRIES(CACHE_ENTRIES)
   ) u_cache (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (learn),
      .wr_ip_i    (req_spa_q),
      .wr_mac_i   (req_sha_q),
      .lk_en_i    (lookup_req_valid && lookup_req_ready),
      .lk_ip_i    (lookup_req_ip),
      .lk_valid_o (lookup_resp_valid),
      .lk_hit_o   (lookup_resp_hit),
      .lk_mac_o   (lookup_resp_mac)
   );
`else
   logic lk_valid_q;
   logic unused_lookup;
   assign unused_lookup = ^lookup_req_ip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lk_valid_q <= 1'b0;
      else        lk_valid_q <= lookup_req_valid && lk_en_q;
   end

   assign lookup_req_ready  = lk_en_q;
   assign lookup_resp_valid = lk_valid_q;
   assign lookup_resp_hit   = 1'b0;
   assign lookup_resp_mac   = '0;
`endif

endmodule

// File: tb/tb_arp_reply_gen.sv
module tb_arp_reply_gen;

   localparam int unsigned CACHE_N = 4;
`ifdef ARP_CACHE_EN
   localparam bit CACHE_ON = 1'b1;
`else
   localparam bit CACHE_ON = 1'b0;
`endif
   localparam logic [31:0] LOCAL_IP  = 32'h0A00_0001;
   localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_frame_valid = 1'b0, s_frame_ready;
   logic [47:0] s_eth_dest_mac = '0, s_eth_src_mac = '0;
   logic [15:0] s_eth_type = '0, s_arp_htype = '0, s_arp_ptype = '0, s_arp_oper = '0;
   logic [7:0]  s_arp_hlen = '0, s_arp_plen = '0;
   logic [47:0] s_arp_sha = '0, s_arp_tha = '0;
   logic [31:0] s_arp_spa = '0, s_arp_tpa = '0;
   logic [47:0] local_mac = LOCAL_MAC;
   logic [31:0] local_ip = LOCAL_IP;
   logic        m_frame_valid, m_frame_ready = 1'b0;
   logic [47:0] m_eth_dest_mac, m_eth_src_mac, m_arp_sha, m_arp_tha;
   logic [15:0] m_eth_type, m_arp_htype, m_arp_ptype, m_arp_oper;
   logic [7:0]  m_arp_hlen, m_arp_plen;
   logic [31:0] m_arp_spa, m_arp_tpa;
   logic        lookup_req_valid = 1'b0, lookup_req_ready;
   logic [31:0] lookup_req_ip = '0;
   logic        lookup_resp_valid, lookup_resp_hit;
   logic [47:0] lookup_resp_mac;
   logic        stat_reply_sent, stat_frame_drop;

   always #5 clk = ~clk;

   arp_reply_gen #(.CACHE_ENTRIES(CACHE_N)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_frame_valid(s_frame_valid), .s_frame_ready(s_frame_ready),
      .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
      .s_arp_htype(s_arp_htype), .s_arp_ptype(s_arp_ptype), .s_arp_oper(s_arp_oper),
      .s_arp_hlen(s_arp_hlen), .s_arp_plen(s_arp_plen),
      .s_arp_sha(s_arp_sha), .s_arp_tha(s_arp_tha), .s_arp_spa(s_arp_spa), .s_arp_tpa(s_arp_tpa),
      .local_mac(local_mac), .local_ip(local_ip),
      .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
      .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
      .m_arp_htype(m_arp_htype), .m_arp_ptype(m_arp_ptype), .m_arp_oper(m_arp_oper),
      .m_arp_hlen(m_arp_hlen), .m_arp_plen(m_arp_plen),
      .m_arp_sha(m_arp_sha), .m_arp_tha(m_arp_tha), .m_arp_spa(m_arp_spa), .m_arp_tpa(m_arp_tpa),
      .lookup_req_valid(lookup_req_valid), .lookup_req_ready(lookup_req_ready),
      .lookup_req_ip(lookup_req_ip),
      .lookup_resp_valid(lookup_resp_valid), .lookup_resp_hit(lookup_resp_hit),
      .lookup_resp_mac(lookup_resp_mac),
      .stat_reply_sent(stat_reply_sent), .stat_frame_drop(stat_frame_drop)
   );

   typedef struct {
      logic [47:0] dmac, smac, sha, tha;
      logic [15:0] etype, htype, ptype, oper;
      logic [7:0]  hlen, plen;
      logic [31:0] spa, tpa;
   } frame_t;

   typedef struct packed {
      logic [31:0] ip;
      logic [47:0] mac;
   } ent_t;

   // Reference cache: insertion-ordered list, oldest allocation evicted first
   ent_t model_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [335:0] got_vec;
   logic [390:0] all_out;
   assign got_vec = {m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_arp_htype, m_arp_ptype,
                     m_arp_oper, m_arp_hlen, m_arp_plen, m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa};
   assign all_out = {got_vec, m_frame_valid, s_frame_ready, lookup_req_ready, lookup_resp_valid,
                     lookup_resp_hit, lookup_resp_mac, stat_reply_sent, stat_frame_drop};

   function automatic frame_t make_frame(input logic [47:0] sha, input logic [31:0] spa,
                                         input logic [31:0] tpa, input logic [15:0] oper);
      frame_t f;
      f.dmac = 48'hFFFF_FFFF_FFFF; f.smac = sha; f.etype = 16'h0806;
      f.htype = 16'd1; f.ptype = 16'h0800; f.hlen = 8'd6; f.plen = 8'd4; f.oper = oper;
      f.sha = sha; f.spa = spa; f.tha = '0; f.tpa = tpa;
      return f;
   endfunction

   function automatic bit hdr_good(input frame_t f);
      return f.htype == 16'd1 && f.ptype == 16'h0800 && f.hlen == 8'd6 && f.plen == 8'd4;
   endfunction

   function automatic bit exp_answer(input frame_t f, input logic [31:0] li);
      return hdr_good(f) && f.oper == 16'd1 && f.tpa == li && li != 32'd0;
   endfunction

   function automatic bit exp_learn(input frame_t f);
      return hdr_good(f) && (f.oper == 16'd1 || f.oper == 16'd2) && f.spa != 32'd0;
   endfunction

   function automatic logic [335:0] exp_reply(input frame_t f, input logic [47:0] lm,
                                              input logic [31:0] li);
      return {f.sha, lm, 16'h0806, 16'd1, 16'h0800, 16'd2, 8'd6, 8'd4, lm, li, f.sha, f.spa};
   endfunction

   function automatic void model_learn(input logic [31:0] ip, input logic [47:0] mac);
      if (!CACHE_ON) return;
      foreach (model_q[i]) begin
         if (model_q[i].ip == ip) begin
            model_q[i].mac = mac;
            return;
         end
      end
      if (model_q.size() == CACHE_N) void'(model_q.pop_front());
      model_q.push_back({ip, mac});
   endfunction

   function automatic void model_lookup(input logic [31:0] ip, output bit hit,
                                        output logic [47:0] mac);
      hit = 1'b0;
      mac = '0;
      foreach (model_q[i]) begin
         if (model_q[i].ip == ip) begin
            hit = 1'b1;
            mac = model_q[i].mac;
         end
      end
   endfunction

   task automatic drive_frame(input frame_t f);
      s_eth_dest_mac = f.dmac; s_eth_src_mac = f.smac; s_eth_type = f.etype;
      s_arp_htype = f.htype; s_arp_ptype = f.ptype; s_arp_oper = f.oper;
      s_arp_hlen = f.hlen; s_arp_plen = f.plen;
      s_arp_sha = f.sha; s_arp_tha = f.tha; s_arp_spa = f.spa; s_arp_tpa = f.tpa;
   endtask

   // Holds s_frame_valid until a handshake edge; returns 1 ns after that edge
   task automatic wait_accept(output bit ok);
      bit rdy;
      ok = 1'b0;
      s_frame_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rdy = s_frame_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      s_frame_valid = 1'b0;
   endtask

   task automatic run_frame(input string name, input frame_t f, input int hold, input bit perturb);
      bit ok, rep, lrn;
      logic [335:0] ev;
      drive_frame(f);
      wait_accept(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s accept_timeout got=0 exp=1", name);
         return;
      end
      rep = exp_answer(f, local_ip);
      lrn = exp_learn(f);
      ev  = exp_reply(f, local_mac, local_ip);
      // CHECK cycle
      n_checks++;
      if (stat_frame_drop !== !rep) begin
         n_fail++; $display("FAIL %s drop_pulse got=%0b exp=%0b", name, stat_frame_drop, !rep);
      end
      n_checks++;
      if (lookup_req_ready !== (CACHE_ON ? !lrn : 1'b1)) begin
         n_fail++; $display("FAIL %s lookup_ready_in_check got=%0b exp=%0b", name,
                            lookup_req_ready, (CACHE_ON ? !lrn : 1'b1));
      end
      n_checks++;
      if ({s_frame_ready, m_frame_valid} !== 2'b00) begin
         n_fail++; $display("FAIL %s check_cycle_ready_valid got=%b exp=00", name,
                            {s_frame_ready, m_frame_valid});
      end
      if (lrn) model_learn(f.spa, f.sha);
      @(posedge clk); #1;
      n_checks++;
      if ({m_frame_valid, s_frame_ready, stat_frame_drop} !== {rep, !rep, 1'b0}) begin
         n_fail++; $display("FAIL %s n2_valid_ready_drop got=%b exp=%b", name,
                            {m_frame_valid, s_frame_ready, stat_frame_drop}, {rep, !rep, 1'b0});
      end
      if (!rep) return;
      n_checks++;
      if (got_vec !== ev) begin
         n_fail++; $display("FAIL %s reply_fields got=%h exp=%h", name, got_vec, ev);
      end
      if (perturb) begin
         local_mac = ~LOCAL_MAC;
         local_ip  = 32'hC0A8_0101;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({m_frame_valid, s_frame_ready, stat_reply_sent} !== 3'b100 || got_vec !== ev) begin
            n_fail++; $display("FAIL %s hold%0d got=%b/%h exp=100/%h", name, i,
                               {m_frame_valid, s_frame_ready, stat_reply_sent}, got_vec, ev);
         end
      end
      m_frame_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (stat_reply_sent !== 1'b1) begin
         n_fail++; $display("FAIL %s reply_sent_pulse got=%0b exp=1", name, stat_reply_sent);
      end
      @(posedge clk); #1;
      m_frame_ready = 1'b0;
      n_checks++;
      if ({m_frame_valid, s_frame_ready, stat_reply_sent} !== 3'b010) begin
         n_fail++; $display("FAIL %s after_handshake got=%b exp=010", name,
                            {m_frame_valid, s_frame_ready, stat_reply_sent});
      end
      local_mac = LOCAL_MAC;
      local_ip  = LOCAL_IP;
   endtask

   task automatic do_lookup(input string name, input logic [31:0] ip);
      bit eh, rdy;
      logic [47:0] em;
      model_lookup(ip, eh, em);
      lookup_req_valid = 1'b1;
      lookup_req_ip    = ip;
      rdy = 1'b0;
      for (int i = 0; i < 20 && !rdy; i++) begin
         @(negedge clk);
         rdy = lookup_req_ready;
         @(posedge clk); #1;
      end
      lookup_req_valid = 1'b0;
      n_checks++;
      if ({rdy, lookup_resp_valid, lookup_resp_hit, lookup_resp_mac} !== {2'b11, eh, em}) begin
         n_fail++; $display("FAIL %s lookup %h got=%b%b%b_%h exp=11%b_%h", name, ip, rdy,
                            lookup_resp_valid, lookup_resp_hit, lookup_resp_mac, eh, em);
      end
      @(posedge clk); #1;
      n_checks++;
      if (lookup_resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL %s resp_one_cycle got=%0b exp=0", name, lookup_resp_valid);
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_outputs got=%h exp=0", all_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_checks++;
      if ({s_frame_ready, lookup_req_ready} !== 2'b00) begin
         n_fail++; $display("FAIL reset_release_ready got=%b exp=00", {s_frame_ready, lookup_req_ready});
      end
      @(posedge clk); #1;
      n_checks++;
      if ({s_frame_ready, lookup_req_ready} !== 2'b11) begin
         n_fail++; $display("FAIL ready_rise got=%b exp=11", {s_frame_ready, lookup_req_ready});
      end
   endtask

   task automatic test_reply();
      run_frame("basic_reply", make_frame(48'h0200_0000_00AA, 32'h0A00_0002, LOCAL_IP, 16'd1), 0, 1'b0);
   endtask

   task automatic test_drop_and_learn();
      run_frame("wrong_tpa", make_frame(48'h0200_0000_00AA, 32'h0A00_0002, 32'h0A00_0009, 16'd1), 0, 1'b0);
      do_lookup("learned_sender", 32'h0A00_0002);
   endtask

   task automatic test_bad_frames();
      frame_t f;
      f = make_frame(48'h0200_0000_00BB, 32'h0A00_0003, LOCAL_IP, 16'd1);
      f.hlen = 8'd5;
      run_frame("bad_hlen", f, 0, 1'b0);
      do_lookup("bad_hlen_not_learned", 32'h0A00_0003);
      f = make_frame(48'h0200_0000_00CC, 32'h0A00_0005, LOCAL_IP, 16'd1);
      f.ptype = 16'h86DD;
      run_frame("bad_ptype", f, 0, 1'b0);
      run_frame("oper_reply_to_local", make_frame(48'h0200_0000_00DD, 32'h0A00_0006, LOCAL_IP, 16'd2), 0, 1'b0);
      do_lookup("oper2_learned", 32'h0A00_0006);
      local_ip = 32'd0;
      run_frame("local_ip_zero", make_frame(48'h0200_0000_00EE, 32'd0, 32'd0, 16'd1), 0, 1'b0);
      local_ip = LOCAL_IP;
   endtask

   task automatic test_backpressure();
      run_frame("backpressure", make_frame(48'h0200_0000_0044, 32'h0A00_0004, LOCAL_IP, 16'd1), 10, 1'b1);
   endtask

   task automatic test_cache_replace();
      frame_t f;
      for (int k = 1; k <= 5; k++) begin
         f = make_frame(48'h0200_0000_0100 + 48'(k), 32'h0A00_0100 + 32'(k), 32'h0A00_0032, 16'd2);
         run_frame("learn_sender", f, 0, 1'b0);
      end
      do_lookup("first_sender_evicted", 32'h0A00_0101);
      do_lookup("fifth_sender_present", 32'h0A00_0105);
      run_frame("relearn_sender2", make_frame(48'h0200_0000_0222, 32'h0A00_0102, 32'h0A00_0032, 16'd2), 0, 1'b0);
      do_lookup("sender2_updated", 32'h0A00_0102);
      do_lookup("sender3_kept", 32'h0A00_0103);
   endtask

   task automatic test_back_to_back();
      logic [31:0] ips [6];
      bit eh;
      logic [47:0] em;
      ips = '{32'h0A00_0105, 32'h0A00_0101, 32'h0A00_0102, 32'h0A00_0104, 32'hDEAD_BEEF, 32'h0A00_0103};
      lookup_req_valid = 1'b1;
      lookup_req_ip    = ips[0];
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (lookup_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready%0d got=%0b exp=1", k, lookup_req_ready);
         end
         @(posedge clk); #1;
         model_lookup(ips[k], eh, em);
         if (k < 5) lookup_req_ip = ips[k+1];
         else       lookup_req_valid = 1'b0;
         n_checks++;
         if ({lookup_resp_valid, lookup_resp_hit, lookup_resp_mac} !== {1'b1, eh, em}) begin
            n_fail++; $display("FAIL b2b_resp%0d got=%b%b_%h exp=1%b_%h", k, lookup_resp_valid,
                               lookup_resp_hit, lookup_resp_mac, eh, em);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (lookup_resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_end got=%0b exp=0", lookup_resp_valid);
      end
   endtask

   task automatic test_random();
      logic [31:0] pool [6];
      frame_t f;
      pool = '{32'd0, 32'h0A00_0002, 32'h0A00_0007, 32'h0A00_0008, 32'h0A00_0101, 32'h0A00_0104};
      for (int n = 0; n < 30; n++) begin
         f = make_frame({16'h0200, $urandom()}, pool[$urandom_range(0, 5)],
                        ($urandom_range(0, 2) == 0) ? 32'h0A00_0063 : LOCAL_IP,
                        16'($urandom_range(1, 3)));
         case ($urandom_range(0, 9))
            0: f.htype = 16'd6;
            1: f.ptype = 16'h86DD;
            2: f.hlen  = 8'd5;
            3: f.plen  = 8'd16;
            default: ;
         endcase
         run_frame("random", f, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         do_lookup("random", pool[$urandom_range(0, 5)]);
      end
   endtask

   task automatic test_reset_in_reply();
      bit ok;
      drive_frame(make_frame(48'h0200_0000_0077, 32'h0A00_0077, LOCAL_IP, 16'd1));
      wait_accept(ok);
      @(posedge clk); #1;
      n_checks++;
      if ({ok, m_frame_valid} !== 2'b11) begin
         n_fail++; $display("FAIL rst_reply_setup got=%b exp=11", {ok, m_frame_valid});
      end
      m_frame_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_in_reply got=%h exp=0", all_out);
      end
      @(posedge clk); #1;
      n_checks++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_held got=%h exp=0", all_out);
      end
      m_frame_ready = 1'b0;
      rst_n = 1'b1;
      model_q.delete();
      run_frame("after_reset", make_frame(48'h0200_0000_0088, 32'h0A00_0088, LOCAL_IP, 16'd1), 1, 1'b0);
      do_lookup("cache_cleared", 32'h0A00_0002);
   endtask

   initial begin
      test_reset();
      test_reply();
      test_drop_and_learn();
      test_bad_frames();
      test_backpressure();
      test_cache_replace();
      test_back_to_back();
      test_random();
      test_reset_in_reply();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
